// File: rtl/hex_disp_scan.sv
// Multiplexed hex display scanner: per-digit slot scan with PWM dimming,
// leading-zero blanking and tear-free frame-boundary updates.
module hex_disp_scan #(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned REFRESH_DIV = 12500,
    parameter int unsigned PWM_BITS    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  blank_lz,
    input  logic [PWM_BITS-1:0]   brightness,
    output logic [N_DIGITS-1:0]   an,
    output logic [7:0]            sseg,
    output logic                  frame_tick
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned VAL_W = 4 * N_DIGITS;

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [PWM_BITS-1:0] r_pwm;
    logic [VAL_W-1:0]    r_disp_val;
    logic [N_DIGITS-1:0] r_disp_dp;
    logic [VAL_W-1:0]    r_pend_val;
    logic [N_DIGITS-1:0] r_pend_dp;
    logic                r_pend_valid;
    logic [N_DIGITS-1:0] r_an;
    logic [7:0]          r_sseg;
    logic                r_frame_tick;

    logic                w_slot_tick;
    logic                w_frame_end;
    logic [N_DIGITS-1:0] w_blank;
    logic [3:0]          w_nib;
    logic                w_dp;
    logic                w_blank_cur;
    logic                w_lit;
    logic [6:0]          w_seg7;
    logic [N_DIGITS-1:0] w_an_nxt;

    function automatic logic [6:0] f_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'b0000001;
            4'h1: g = 7'b1001111;
            4'h2: g = 7'b0010010;
            4'h3: g = 7'b0000110;
            4'h4: g = 7'b1001100;
            4'h5: g = 7'b0100100;
            4'h6: g = 7'b0100000;
            4'h7: g = 7'b0001111;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0000100;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b1100000;
            4'hC: g = 7'b0110001;
            4'hD: g = 7'b1000010;
            4'hE: g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        return g;
    endfunction

    assign w_slot_tick = (r_cnt == CNT_W'(REFRESH_DIV - 1));
    assign w_frame_end = w_slot_tick && (r_idx == IDX_W'(N_DIGITS - 1));

    // A digit is blank when it and every digit to its left are zero; digit 0 never blanks.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        w_blank    = '0;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (r_disp_val[4*i +: 4] == 4'h0);
            w_blank[i] = blank_lz && zero_above;
        end
    end

    assign w_nib       = r_disp_val[{r_idx, 2'b00} +: 4];
    assign w_dp        = r_disp_dp[r_idx];
    assign w_blank_cur = w_blank[r_idx];
    assign w_lit       = (r_pwm <= brightness) && (!w_blank_cur || w_dp);
    assign w_seg7      = w_blank_cur ? 7'h7F : f_glyph(w_nib);
    assign w_an_nxt    = ~(N_DIGITS'(w_lit) << r_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_pwm        <= '0;
            r_disp_val   <= '0;
            r_disp_dp    <= '0;
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
            r_an         <= '1;
            r_sseg       <= 8'hFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_cnt        <= w_slot_tick ? '0 : r_cnt + CNT_W'(1);
            r_pwm        <= r_pwm + PWM_BITS'(1);
            r_frame_tick <= w_frame_end;
            r_an         <= w_an_nxt;
            r_sseg       <= {~w_dp, w_seg7};
            if (w_slot_tick) begin
                r_idx <= (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
            end
            if (load) begin
                r_pend_val   <= value;
                r_pend_dp    <= dp_in;
                r_pend_valid <= 1'b1;
            end
            // Displayed digits only change at the frame boundary; a same-cycle load wins.
            if (w_frame_end) begin
                r_pend_valid <= 1'b0;
                if (load) begin
                    r_disp_val <= value;
                    r_disp_dp  <= dp_in;
                end else if (r_pend_valid) begin
                    r_disp_val <= r_pend_val;
                    r_disp_dp  <= r_pend_dp;
                end
            end
        end
    end

    assign an         = r_an;
    assign sseg       = r_sseg;
    assign frame_tick = r_frame_tick;

endmodule

// File: doc/hex_disp_scan.md
HEX_DISP_SCAN -- requirements
Module: hex_disp_scan

Interface
REQ-001 The block SHALL have the following parameters:
- N_DIGITS, default 4: number of digits, legal range 2..8.
- REFRESH_DIV, default 12500: clk cycles per digit slot, legal range ≥2.
- PWM_BITS, default 4: width of the brightness control.

REQ-002 The block SHALL have the following ports (clock and reset first):
- clk  in  1: system clock; one clock domain; all logic on its rising edge.
- reset  in  1: synchronous, active-high reset.
- load  in  1: single-cycle strobe that captures value and dp_in.
- value  in  4*N_DIGITS: hex digits; digit i = value[4i+3:4i]; digit 0 is rightmost.
- dp_in  in  N_DIGITS: decimal point enables, 1 = point lit.
- blank_lz  in  1: 1 = suppress leading zeros.
- brightness  in  PWM_BITS: duty select.
- an  out  N_DIGITS: digit enables, active-low.
- sseg  out  8: segments, active-low; sseg[7]=dp, sseg[6:0]=a..g (a at bit 6).
- frame_tick  out  1: one-cycle pulse at the end of each full scan.

Function
REQ-003 Prescaler cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; slot_tick SHALL equal (cnt==REFRESH_DIV-1).
REQ-004 Digit index idx SHALL advance on slot_tick and wrap from N_DIGITS-1 to 0.
REQ-005 frame_tick SHALL be 1 for exactly the cycle after slot_tick with idx==N_DIGITS-1, and 0 otherwise.
REQ-006 load=1 SHALL capture value/dp_in into pending registers and set pend_valid; a later load overwrites the pending registers (last load wins).
REQ-007 The displayed registers SHALL update only at frame end (slot_tick with idx==N_DIGITS-1), as follows:
- If load is 1 in that cycle, the displayed registers take value/dp_in directly.
- Otherwise, if pend_valid is set, they take the pending registers.
- pend_valid SHALL clear in that cycle.
REQ-008 There SHALL be no display update mid-frame (tear-free).
REQ-009 A free-running PWM_BITS counter pwm SHALL increment every cycle and wrap.
REQ-010 The digit SHALL be lit only while pwm <= brightness:
- brightness = all-ones gives a 100% duty cycle.
- brightness = 0 gives a 1/2^PWM_BITS duty cycle.
REQ-011 When blank_lz=1, digit i (i≥1) SHALL be blank if displayed digits N_DIGITS-1..i are all 0; digit 0 SHALL never be blank.
REQ-012 For a blank digit:
- sseg[6:0] SHALL be 1111111.
- If its dp bit is 1, the anode SHALL be driven (subject to PWM) with sseg[7]=0.
- If its dp bit is 0, the anode SHALL stay off.
REQ-013 Glyphs (sseg[6:0]) SHALL be:
- 0=0000001, 1=1001111, 2=0010010, 3=0000110
- 4=1001100, 5=0100100, 6=0100000, 7=0001111
- 8=0000000, 9=0000100, A=0001000, b=1100000
- C=0110001, d=1000010, E=0110000, F=0111000
REQ-014 For a lit digit, sseg[7] SHALL equal the inverse of the displayed dp bit of digit idx.
REQ-015 an SHALL be all ones except bit idx, which is 0 when that digit is lit per REQ-010/REQ-012.
REQ-016 an and sseg SHALL be registered, with one cycle of latency from idx/cnt/pwm; at most one an bit SHALL be low in any cycle.
REQ-017 Changes on brightness or blank_lz SHALL take effect on the next cycle, with no frame-boundary wait.

Reset
REQ-018 On reset=1 at a clock edge, the following SHALL clear:
- cnt=0, idx=0, pwm=0.
- Displayed and pending value and dp registers = 0; pend_valid=0.
- Outputs: an=all ones, sseg=8'hFF, frame_tick=0.
REQ-019 Reset SHALL take priority over load; reset asserted mid-frame SHALL discard the pending load, and scanning SHALL restart at digit 0 on the first cycle after reset deasserts.

Verification (N_DIGITS=4, REFRESH_DIV=4, PWM_BITS=2 unless noted)
REQ-020 Reset, then brightness=3, no load -> an cycles 1110,1101,1011,0111, each for 4 cycles; sseg=0000001 on all digits (all digits read 0); frame_tick pulses every 16 cycles.
REQ-021 load value=16'h12AF at mid-frame -> display shows 0 until the frame end; from the next frame, digit 0 sseg[6:0]=0111000 and digit 3 =1001111.
REQ-022 blank_lz=1, value=16'h0050, dp_in=4'b1000 -> digit 3 anode lit with sseg=01111111; digit 2 anode off; digits 1 and 0 show 5 and 0.
REQ-023 brightness=0 -> each an bit is low for 1 cycle in every 4 within its slot; brightness=2 -> low for 3 of 4.
REQ-024 load at the frame-end cycle, plus an earlier pending load, -> the frame-end load value is displayed, the pending value is never displayed, and pend_valid=0.
REQ-025 Reset asserted for 1 cycle mid-slot with a load pending -> outputs match REQ-018; after release, digit 0 shows 0 and the pending value is never displayed.
